series_adder_word_packer: RTL

- Upstream feeder for series_adder_data_streamer.
- Accepts a serial stream of W-bit words over a valid/ready handshake and packs M words into a flat M*W vector (slot i at bits [W*i+W-1 : W*i]).
- Emits a one-cycle data_vld pulse to the streamer only while the streamer's data_rdy is high.
- Short frames (in_last before M words) are zero-padded, so the adder sums only the real words.

---
 rtl/series_adder_pkg.sv | 24 ++
 rtl/series_adder_word_packer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/series_adder_pkg.sv
// Shared definitions for the series adder front end (word packer and streamer).
//   M_DEF / W_DEF / CNT_W_DEF : default frame size, operand width, frame counter width
//   SUM_W_DEF                 : natural adder result width for the defaults (35; the streamer widens to 40)
//   pack_state_e              : packer FSM encoding
//   slot_lsb()                : LSB position of operand slot i in a flat M*W vector
package series_adder_pkg;

   localparam int M_DEF     = 8;
   localparam int W_DEF     = 32;
   localparam int CNT_W_DEF = 16;
   localparam int SUM_W_DEF = W_DEF + $clog2(M_DEF);

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      WAIT_RDY = 2'd1,
      PULSE    = 2'd2
   } pack_state_e;

   // Slot i occupies bits [width*i + width-1 : width*i].
   function automatic int slot_lsb(input int slot, input int width);
      return slot * width;
   endfunction

endpackage

// File: rtl/series_adder_word_packer.sv
// Packs a serial stream of W-bit operands into one flat M*W frame and hands it
// to the series adder streamer with a single-cycle strobe.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// FILL     | accepting words (in_rdy=1); frame closes on slot M-1 or in_last
// WAIT_RDY | frame complete, held stable until streamer data_rdy is sampled
// PULSE    | data_vld high for this one cycle; buffer clears on exit
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_data/in_vld/in_last/in_rdy   serial operand input handshake
//   data_o, data_vld, data_rdy      packed frame output toward the streamer
//   frame_len           real (non-pad) words in the current/last frame
//   frame_cnt           frames issued since reset, wraps silently
module series_adder_word_packer
   import series_adder_pkg::*;
#(
   parameter int M     = M_DEF,
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [W-1:0]           in_data,
   input  logic                   in_vld,
   input  logic                   in_last,
   output logic                   in_rdy,
   output logic [M*W-1:0]         data_o,
   output logic                   data_vld,
   input  logic                   data_rdy,
   output logic [$clog2(M+1)-1:0] frame_len,
   output logic [CNT_W-1:0]       frame_cnt
);

   localparam int IDX_W = $clog2(M);
   localparam int LEN_W = $clog2(M+1);

   pack_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [M*W-1:0]   data_q, data_d;
   logic             vld_q, vld_d;
   logic             rdy_q, rdy_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [M-1:0]     slot_we;
   logic             accept;

   assign accept = (state_q == FILL) && rdy_q && in_vld;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      vld_d   = 1'b0;
      rdy_d   = rdy_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      slot_we = '0;

      case (state_q)
         FILL: begin
            // rdy_q is low only in the first cycle after reset; raise it here.
            rdy_d = 1'b1;
            if (accept) begin
               slot_we[idx_q] = 1'b1;
               idx_d = idx_q + IDX_W'(1);
               // The previous frame's length stays visible until a new frame starts.
               len_d = (idx_q == '0) ? LEN_W'(1) : len_q + LEN_W'(1);
               if (idx_q == IDX_W'(M-1) || in_last) begin
                  state_d = WAIT_RDY;
                  rdy_d   = 1'b0;
               end
            end
         end
         WAIT_RDY: begin
            rdy_d = 1'b0;
            if (data_rdy) begin
               vld_d   = 1'b1;
               state_d = PULSE;
            end
         end
         PULSE: begin
            // Clearing here is what zero-pads the unused slots of a short frame.
            cnt_d   = cnt_q + CNT_W'(1);
            data_d  = '0;
            idx_d   = '0;
            rdy_d   = 1'b1;
            state_d = FILL;
         end
         default: begin
            state_d = FILL;
            rdy_d   = 1'b0;
         end
      endcase

      for (int i = 0; i < M; i++) begin
         if (slot_we[i]) data_d[slot_lsb(i, W) +: W] = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         idx_q   <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_rdy    = rdy_q;
   assign data_o    = data_q;
   assign data_vld  = vld_q;
   assign frame_len = len_q;
   assign frame_cnt = cnt_q;

endmodule
